// File: rtl/l23_pkg.sv
// Shared types and defaults for the L2/L3 Tx header inserter.
package l23_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } state_e;

endpackage

// File: rtl/l23_hdr_inserter.sv
// Tx sequencer: emits the management-programmed header words from the header RAM,
// then streams one payload frame from the FWFT packet FIFO.
module l23_hdr_inserter
   import l23_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hdr_en_mgmt,
   input  logic              hdr_last_flag,
   input  logic [DATA_W-1:0] hdr_data,
   output logic              hdr_set_zero,
   output logic              hdr_incr,
   input  logic [DATA_W-1:0] pl_data,
   input  logic              pl_valid,
   input  logic              pl_last,
   output logic              pl_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  frame_cnt
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Next-state and handshake decode; the data path is a pure mux with no added latency.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      out_data     = '0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      pl_ready     = 1'b0;
      hdr_incr     = 1'b0;
      hdr_set_zero = 1'b0;

      case (state_q)
         IDLE: begin
            hdr_set_zero = 1'b1;
            if (pl_valid) begin
               state_d = hdr_en_mgmt ? HDR : PAYLOAD;
            end
         end
         HDR: begin
            out_data  = hdr_data;
            out_valid = 1'b1;
            hdr_incr  = out_ready;
            if (out_ready && hdr_last_flag) begin
               hdr_set_zero = 1'b1;
               state_d      = PAYLOAD;
            end
         end
         PAYLOAD: begin
            out_data  = pl_data;
            out_valid = pl_valid;
            out_last  = pl_last;
            pl_ready  = out_ready;
            if (pl_valid && out_ready && pl_last) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign frame_cnt = cnt_q;

endmodule
